// File: rtl/sfp_poll_pkg.sv
// Shared definitions for the SFP I2C poll arbiter: core CSR map, TFR_CMD encoding,
// poll table layout and the arbiter state encoding.
package sfp_poll_pkg;

    localparam int POLL_TABLE_LEN = 11;

    localparam logic [31:0] TFR_CMD_OFS = 32'h0000_0000;
    localparam logic [31:0] RX_DATA_OFS = 32'h0000_0004;
    localparam logic [31:0] RX_LVL_OFS  = 32'h0000_001C;

    localparam int TFR_STA_BIT = 9;
    localparam int TFR_STO_BIT = 8;

    typedef struct packed {
        logic [6:0] dev;
        logic [7:0] offset;
    } poll_entry_t;

    typedef poll_entry_t [POLL_TABLE_LEN-1:0] poll_table_t;

    typedef enum logic [3:0] {
        IDLE, H_ACC, H_ISS, H_RSP,
        CMD0, CMD1, CMD2, CMD3,
        LVL_RD, LVL_WT, RX_RD, RX_WT,
        NEXT
    } state_t;

    // A2h page (7-bit 0x51): DDM bytes 96..105 followed by the status byte 110.
    function automatic poll_table_t default_poll_table();
        poll_table_t t;
        for (int i = 0; i < POLL_TABLE_LEN; i++) begin
            t[i].dev    = 7'h51;
            t[i].offset = (i < 10) ? 8'(96 + i) : 8'd110;
        end
        return t;
    endfunction

    localparam poll_table_t POLL_TABLE = default_poll_table();

    function automatic logic [31:0] tfr_word(input logic sta, input logic sto, input logic [7:0] data);
        logic [31:0] w;
        w              = '0;
        w[TFR_STA_BIT] = sta;
        w[TFR_STO_BIT] = sto;
        w[7:0]         = data;
        return w;
    endfunction

endpackage

// File: rtl/sfp_i2c_poll_arbiter_if.sv
// Avalon-MM CSR bundle; the arbiter uses one copy as slave (host side) and one as master (core side).
interface sfp_i2c_poll_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sfp_poll_tick_gen.sv
// Poll period counter; raises a saturating pending flag each time the period elapses.
module sfp_poll_tick_gen #(
    parameter int POLL_PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [CNT_W-1:0] count;
    logic             terminal;

    assign terminal = enable && (count == CNT_W'(POLL_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end

    // A new tick wins over a same-cycle clear so no period is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (terminal) begin
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sfp_i2c_poll_arbiter.sv
// Sole master of the SFP I2C core CSR port: polls a byte table into shadow registers and
// interleaves host pass-through accesses between whole I2C byte transactions.
module sfp_i2c_poll_arbiter
    import sfp_poll_pkg::*;
#(
    parameter int          NUM_POLL     = 11,
    parameter int          POLL_PERIOD  = 100_000_000,
    parameter int          LVL_TIMEOUT  = 4096,
    parameter logic [31:0] I2C_BASE     = 32'h0,
    parameter poll_table_t POLL_TABLE_P = POLL_TABLE
) (
    input  logic                      clk,
    input  logic                      rst,
    sfp_i2c_poll_arbiter_if.slave     avs,
    sfp_i2c_poll_arbiter_if.master    avm,
    input  logic                      poll_enable,
    output logic [8*NUM_POLL-1:0]     shadow_data,
    output logic                      shadow_valid,
    output logic [NUM_POLL-1:0]       poll_err,
    output logic                      cycle_done
);

    localparam int IDX_W = (NUM_POLL > 1) ? $clog2(NUM_POLL) : 1;
    localparam int TRY_W = $clog2(LVL_TIMEOUT + 1);

    state_t           state, next_state;
    logic [IDX_W-1:0] index;
    logic [TRY_W-1:0] tries;
    logic             pending;
    logic             clear_pending;

    logic [31:0]      cap_address;
    logic [31:0]      cap_writedata;
    logic [3:0]       cap_byteenable;
    logic             cap_write;
    logic [31:0]      rsp_data;
    logic             rsp_valid;

    poll_entry_t      entry;
    logic             last_entry;
    logic             lvl_nonzero;
    logic             lvl_timeout;

    assign entry         = POLL_TABLE_P[index];
    assign last_entry    = (index == IDX_W'(NUM_POLL - 1));
    assign lvl_nonzero   = (avm.readdata != 32'h0);
    assign lvl_timeout   = (tries == TRY_W'(LVL_TIMEOUT - 1));
    assign clear_pending = (state == NEXT) && last_entry;

    sfp_poll_tick_gen #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .enable  (poll_enable),
        .clear   (clear_pending),
        .pending (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Host is only considered in IDLE, so it never splits an I2C byte transaction.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (avs.read || avs.write) begin
                    next_state = H_ACC;
                end else if ((pending || index != '0) && poll_enable) begin
                    next_state = CMD0;
                end
            end
            H_ACC:  next_state = H_ISS;
            H_ISS:  if (!avm.waitrequest) next_state = cap_write ? IDLE : H_RSP;
            H_RSP:  if (avm.readdatavalid) next_state = IDLE;
            CMD0:   if (!avm.waitrequest) next_state = CMD1;
            CMD1:   if (!avm.waitrequest) next_state = CMD2;
            CMD2:   if (!avm.waitrequest) next_state = CMD3;
            CMD3:   if (!avm.waitrequest) next_state = LVL_RD;
            LVL_RD: if (!avm.waitrequest) next_state = LVL_WT;
            LVL_WT: begin
                if (avm.readdatavalid) begin
                    if (lvl_nonzero)      next_state = RX_RD;
                    else if (lvl_timeout) next_state = NEXT;
                    else                  next_state = LVL_RD;
                end
            end
            RX_RD:  if (!avm.waitrequest) next_state = RX_WT;
            RX_WT:  if (avm.readdatavalid) next_state = NEXT;
            NEXT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        avm.address     = '0;
        avm.read        = 1'b0;
        avm.write       = 1'b0;
        avm.byteenable  = '0;
        avm.writedata   = '0;
        avs.waitrequest = (state != H_ACC);
        case (state)
            H_ISS: begin
                avm.address    = cap_address;
                avm.read       = !cap_write;
                avm.write      = cap_write;
                avm.byteenable = cap_byteenable;
                avm.writedata  = cap_writedata;
            end
            CMD0, CMD1, CMD2, CMD3: begin
                avm.address    = I2C_BASE + TFR_CMD_OFS;
                avm.write      = 1'b1;
                avm.byteenable = 4'hF;
                case (state)
                    CMD0:    avm.writedata = tfr_word(1'b1, 1'b0, {entry.dev, 1'b0});
                    CMD1:    avm.writedata = tfr_word(1'b0, 1'b0, entry.offset);
                    CMD2:    avm.writedata = tfr_word(1'b1, 1'b0, {entry.dev, 1'b1});
                    default: avm.writedata = tfr_word(1'b0, 1'b1, 8'h00);
                endcase
            end
            LVL_RD: begin
                avm.address    = I2C_BASE + RX_LVL_OFS;
                avm.read       = 1'b1;
                avm.byteenable = 4'hF;
            end
            RX_RD: begin
                avm.address    = I2C_BASE + RX_DATA_OFS;
                avm.read       = 1'b1;
                avm.byteenable = 4'hF;
            end
            default: ;
        endcase
    end

    assign avs.readdata      = rsp_data;
    assign avs.readdatavalid = rsp_valid;

    // A level-poll timeout leaves the shadow byte stale and flags it; a good read clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_address    <= '0;
            cap_writedata  <= '0;
            cap_byteenable <= '0;
            cap_write      <= 1'b0;
            rsp_data       <= '0;
            rsp_valid      <= 1'b0;
            index          <= '0;
            tries          <= '0;
            shadow_data    <= '0;
            shadow_valid   <= 1'b0;
            poll_err       <= '0;
            cycle_done     <= 1'b0;
        end else begin
            rsp_valid  <= 1'b0;
            cycle_done <= 1'b0;
            if (state == H_ACC) begin
                cap_address    <= avs.address;
                cap_writedata  <= avs.writedata;
                cap_byteenable <= avs.byteenable;
                cap_write      <= avs.write;
            end
            if (state == H_RSP && avm.readdatavalid) begin
                rsp_data  <= avm.readdata;
                rsp_valid <= 1'b1;
            end
            if (state == CMD0) begin
                tries <= '0;
            end
            if (state == LVL_WT && avm.readdatavalid && !lvl_nonzero) begin
                tries <= tries + TRY_W'(1);
                if (lvl_timeout) begin
                    poll_err[index] <= 1'b1;
                end
            end
            if (state == RX_WT && avm.readdatavalid) begin
                shadow_data[8*index +: 8] <= avm.readdata[7:0];
                poll_err[index]           <= 1'b0;
            end
            if (state == NEXT) begin
                if (last_entry) begin
                    index        <= '0;
                    cycle_done   <= 1'b1;
                    shadow_valid <= 1'b1;
                end else begin
                    index <= index + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sfp_i2c_poll_arbiter.sv
// Directed bench for sfp_i2c_poll_arbiter with a behavioural I2C core CSR model on the master side.
module tb_sfp_i2c_poll_arbiter;
    import sfp_poll_pkg::*;

    localparam int NUM_POLL    = 11;
    localparam int POLL_PERIOD = 200;
    localparam int LVL_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic poll_enable = 1'b0;
    logic [8*NUM_POLL-1:0] shadow_data;
    logic                  shadow_valid;
    logic [NUM_POLL-1:0]   poll_err;
    logic                  cycle_done;

    sfp_i2c_poll_arbiter_if avs_if();
    sfp_i2c_poll_arbiter_if avm_if();

    sfp_i2c_poll_arbiter #(
        .NUM_POLL    (NUM_POLL),
        .POLL_PERIOD (POLL_PERIOD),
        .LVL_TIMEOUT (LVL_TIMEOUT),
        .I2C_BASE    (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .avs          (avs_if),
        .avm          (avm_if),
        .poll_enable  (poll_enable),
        .shadow_data  (shadow_data),
        .shadow_valid (shadow_valid),
        .poll_err     (poll_err),
        .cycle_done   (cycle_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Core model state
    int          stall_cnt;
    bit          stall_rand = 1'b0;
    int          lvl_zero_entry = -1;
    logic [7:0]  rx_base = 8'h40;
    int          cur_entry = 0;
    logic [7:0]  last_offset = 8'h00;
    logic [31:0] last_tfr = 32'h0;
    logic [31:0] host_rd_addr = 32'h0;
    int          tfr_total = 0;
    int          rx_total = 0;
    int          lvl_reads [NUM_POLL];
    int          rx_reads  [NUM_POLL];
    logic [31:0] tfr_log [$];
    logic        rd_pend;
    logic [31:0] rd_data;

    assign avm_if.waitrequest   = (avm_if.read || avm_if.write) && (stall_cnt != 0);
    assign avm_if.readdatavalid = rd_pend;
    assign avm_if.readdata      = rd_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_data   <= 32'h0;
            stall_cnt <= 0;
        end else begin
            rd_pend <= 1'b0;
            if (avm_if.read || avm_if.write) begin
                if (stall_cnt != 0) begin
                    stall_cnt <= stall_cnt - 1;
                end else begin
                    stall_cnt <= stall_rand ? int'($urandom_range(5, 0)) : 0;
                    if (avm_if.write) begin
                        if (avm_if.address == 32'h0) begin
                            tfr_log.push_back(avm_if.writedata);
                            tfr_total <= tfr_total + 1;
                            last_tfr  <= avm_if.writedata;
                            if (avm_if.writedata[9:8] == 2'b00) begin
                                last_offset <= avm_if.writedata[7:0];
                                cur_entry   <= (avm_if.writedata[7:0] == 8'd110) ? 10
                                                : int'(avm_if.writedata[7:0]) - 96;
                            end
                        end
                    end else begin
                        rd_pend <= 1'b1;
                        case (avm_if.address)
                            32'h1C: begin
                                rd_data <= (cur_entry == lvl_zero_entry) ? 32'h0 : 32'h1;
                                lvl_reads[cur_entry] <= lvl_reads[cur_entry] + 1;
                            end
                            32'h04: begin
                                rd_data <= {24'h0, rx_base + 8'(cur_entry)};
                                rx_reads[cur_entry] <= rx_reads[cur_entry] + 1;
                                rx_total <= rx_total + 1;
                            end
                            default: begin
                                rd_data      <= 32'hCAFE_0000 | avm_if.address;
                                host_rd_addr <= avm_if.address;
                            end
                        endcase
                    end
                end
            end
        end
    end

    function automatic logic [7:0] shadow_byte(input int i);
        return shadow_data[8*i +: 8];
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NUM_POLL; i++) begin
            lvl_reads[i] = 0;
            rx_reads[i]  = 0;
        end
    endtask

    task automatic wait_cycle_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (cycle_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tfr_delta(input int mark, input int delta, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (tfr_total >= mark + delta) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (avs_if.waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL reset_waitrequest got %b want 1", avs_if.waitrequest); end
        checks++; if (avs_if.readdatavalid !== 1'b0 || avs_if.readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_avs_rsp got %b/%h want 0/0", avs_if.readdatavalid, avs_if.readdata); end
        checks++; if ({avm_if.read, avm_if.write} !== 2'b00 || avm_if.address !== 32'h0) begin errors++; $display("[TB] FAIL reset_avm got rd%b wr%b addr %h want 0", avm_if.read, avm_if.write, avm_if.address); end
        checks++; if (shadow_data !== '0 || shadow_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_shadow got %h/%b want 0/0", shadow_data, shadow_valid); end
        checks++; if (poll_err !== '0 || cycle_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %h/%b want 0/0", poll_err, cycle_done); end
    endtask

    task automatic test_full_cycle();
        bit seen;
        int log_start;
        logic [31:0] exp_words [4];
        exp_words = '{32'h2A2, 32'h060, 32'h2A3, 32'h100};
        stall_rand = 1'b1;
        log_start  = tfr_log.size();
        poll_enable = 1'b1;
        wait_cycle_done(5000, seen);
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL full_cycle_done got %b want 1", seen); end
        @(negedge clk);
        checks++; if (cycle_done !== 1'b0) begin errors++; $display("[TB] FAIL cycle_done_width got %b want 0", cycle_done); end
        for (int i = 0; i < NUM_POLL; i++) begin
            checks++;
            if (shadow_byte(i) !== 8'h40 + 8'(i)) begin errors++; $display("[TB] FAIL shadow_byte_%0d got %h want %h", i, shadow_byte(i), 8'h40 + 8'(i)); end
        end
        checks++; if (shadow_valid !== 1'b1) begin errors++; $display("[TB] FAIL shadow_valid got %b want 1", shadow_valid); end
        checks++; if (poll_err !== '0) begin errors++; $display("[TB] FAIL full_poll_err got %h want 0", poll_err); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tfr_log.size() < log_start + k + 1) begin
                errors++; $display("[TB] FAIL tfr_word_%0d got none want %h", k, exp_words[k]);
            end else if (tfr_log[log_start + k] !== exp_words[k]) begin
                errors++; $display("[TB] FAIL tfr_word_%0d got %h want %h", k, tfr_log[log_start + k], exp_words[k]);
            end
        end
        checks++; if (tfr_log.size() - log_start != 4 * NUM_POLL) begin errors++; $display("[TB] FAIL tfr_count got %0d want %0d", tfr_log.size() - log_start, 4 * NUM_POLL); end
    endtask

    task automatic test_host_during_poll();
        bit seen;
        bit accepted;
        logic [7:0] exp_next;
        int rx_at_issue;
        int tfr_at_acc;
        seen = 1'b0;
        poll_enable = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (avm_if.write && avm_if.address == 32'h0 && avm_if.writedata[9:8] == 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL host_find_cmd1 got %b want 1", seen); end
        exp_next = (avm_if.writedata[7:0] == 8'h69) ? 8'h6E :
                   (avm_if.writedata[7:0] == 8'h6E) ? 8'h60 : avm_if.writedata[7:0] + 8'h01;
        rx_at_issue = rx_total;
        avs_if.address    = 32'h14;
        avs_if.byteenable = 4'hF;
        avs_if.read       = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!avs_if.waitrequest) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (accepted !== 1'b1) begin errors++; $display("[TB] FAIL host_accept got %b want 1", accepted); end
        checks++; if (rx_total - rx_at_issue != 1) begin errors++; $display("[TB] FAIL host_after_byte rx_delta got %0d want 1", rx_total - rx_at_issue); end
        checks++; if (last_tfr !== 32'h100) begin errors++; $display("[TB] FAIL host_after_stop got %h want 00000100", last_tfr); end
        tfr_at_acc = tfr_total;
        @(negedge clk);
        avs_if.read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (avs_if.readdatavalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1 || avs_if.readdata !== 32'hCAFE_0014) begin errors++; $display("[TB] FAIL host_rsp got v%b %h want v1 cafe0014", seen, avs_if.readdata); end
        checks++; if (host_rd_addr !== 32'h14) begin errors++; $display("[TB] FAIL host_fwd_addr got %h want 00000014", host_rd_addr); end
        @(negedge clk);
        checks++; if (avs_if.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL host_rdv_width got %b want 0", avs_if.readdatavalid); end
        wait_tfr_delta(tfr_at_acc, 2, 1000, seen);
        checks++; if (seen !== 1'b1 || last_offset !== exp_next) begin errors++; $display("[TB] FAIL host_next_byte got %b/%h want 1/%h", seen, last_offset, exp_next); end
        wait_cycle_done(5000, seen);
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL host_cycle_done got %b want 1", seen); end
    endtask

    task automatic test_timeout();
        bit seen;
        rx_base = 8'h80;
        lvl_zero_entry = 3;
        clear_counts();
        poll_enable = 1'b1;
        wait_cycle_done(5000, seen);
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL timeout_cycle_done got %b want 1", seen); end
        checks++; if (lvl_reads[3] != LVL_TIMEOUT) begin errors++; $display("[TB] FAIL timeout_lvl_reads got %0d want %0d", lvl_reads[3], LVL_TIMEOUT); end
        checks++; if (poll_err !== 11'h008) begin errors++; $display("[TB] FAIL timeout_poll_err got %h want 008", poll_err); end
        checks++; if (shadow_byte(3) !== 8'h43) begin errors++; $display("[TB] FAIL timeout_shadow3 got %h want 43", shadow_byte(3)); end
        checks++; if (shadow_byte(4) !== 8'h84) begin errors++; $display("[TB] FAIL timeout_shadow4 got %h want 84", shadow_byte(4)); end
        lvl_zero_entry = -1;
        poll_enable = 1'b1;
        wait_cycle_done(5000, seen);
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1 || poll_err !== '0) begin errors++; $display("[TB] FAIL recover_poll_err got %b/%h want 1/000", seen, poll_err); end
        checks++; if (shadow_byte(3) !== 8'h83) begin errors++; $display("[TB] FAIL recover_shadow3 got %h want 83", shadow_byte(3)); end
    endtask

    task automatic test_enable_pause();
        bit seen;
        int mark;
        rx_base = 8'hA0;
        clear_counts();
        poll_enable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (last_offset == 8'h65) begin
                seen = 1'b1;
                break;
            end
        end
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL pause_reach_5 got %b want 1", seen); end
        repeat (300) @(negedge clk);
        checks++; if (rx_reads[5] != 1 || rx_reads[6] != 0 || lvl_reads[6] != 0) begin errors++; $display("[TB] FAIL pause_stop got rx5 %0d rx6 %0d lvl6 %0d want 1 0 0", rx_reads[5], rx_reads[6], lvl_reads[6]); end
        checks++; if (shadow_byte(5) !== 8'hA5 || shadow_byte(6) !== 8'h86) begin errors++; $display("[TB] FAIL pause_shadow got %h %h want a5 86", shadow_byte(5), shadow_byte(6)); end
        mark = tfr_total;
        poll_enable = 1'b1;
        wait_tfr_delta(mark, 2, 1000, seen);
        checks++; if (seen !== 1'b1 || last_offset !== 8'h66) begin errors++; $display("[TB] FAIL resume_index got %b/%h want 1/66", seen, last_offset); end
        wait_cycle_done(5000, seen);
        poll_enable = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL resume_cycle_done got %b want 1", seen); end
        for (int i = 0; i < NUM_POLL; i++) begin
            checks++;
            if (rx_reads[i] != 1) begin errors++; $display("[TB] FAIL resume_rx_reads_%0d got %0d want 1", i, rx_reads[i]); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit seen;
        int mark;
        poll_enable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (avm_if.read && avm_if.address == 32'h4 && !avm_if.waitrequest) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rst_find_rx got %b want 1", seen); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (avs_if.waitrequest !== 1'b1 || avs_if.readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_avs got %b/%b want 1/0", avs_if.waitrequest, avs_if.readdatavalid); end
        checks++; if ({avm_if.read, avm_if.write} !== 2'b00 || avm_if.address !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_avm got %b%b %h want 00 0", avm_if.read, avm_if.write, avm_if.address); end
        checks++; if (shadow_data !== '0 || shadow_valid !== 1'b0 || poll_err !== '0 || cycle_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs got %h %b %h %b want 0", shadow_data, shadow_valid, poll_err, cycle_done); end
        poll_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mark = tfr_total;
        poll_enable = 1'b1;
        wait_tfr_delta(mark, 2, 1000, seen);
        checks++; if (seen !== 1'b1 || last_offset !== 8'h60) begin errors++; $display("[TB] FAIL rst_restart_index got %b/%h want 1/60", seen, last_offset); end
        poll_enable = 1'b0;
    endtask

    initial begin
        avs_if.address    = 32'h0;
        avs_if.read       = 1'b0;
        avs_if.write      = 1'b0;
        avs_if.byteenable = 4'h0;
        avs_if.writedata  = 32'h0;
        clear_counts();
        test_reset();
        test_full_cycle();
        test_host_during_poll();
        test_timeout();
        test_enable_pause();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
